sram_like_slave: RTL and testbench



---
 rtl/sram_like_slave_pkg.sv | 21 ++
 rtl/sram_like_slave_if.sv | 25 ++
 rtl/sram_like_slave_resp_fifo.sv | 63 ++++++
 rtl/sram_like_slave.sv | 107 ++++++++++
 tb/tb_sram_like_slave.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/sram_like_slave_pkg.sv
// Shared types and constants for the sram-like bus responder.
package sram_like_slave_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned STRB_W    = 4;
  localparam int unsigned DLY_W_DEF = 3;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  // One queued response: kind plus the read snapshot taken at acceptance.
  typedef struct packed {
    logic              wr;
    logic [DATA_W-1:0] rdata;
  } resp_t;

endpackage

// File: rtl/sram_like_slave_if.sv
// sram-like request/response bus between a pipeline stage and its memory.
interface sram_like_slave_if;
  import sram_like_slave_pkg::*;

  logic              req;
  logic              wr;
  size_e             size;
  logic [STRB_W-1:0] wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/sram_like_slave_resp_fifo.sv
// In-order response queue; also exposes the post-edge head and count so the
// caller can register data_ok one cycle after acceptance.
module sram_like_slave_resp_fifo
  import sram_like_slave_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  resp_t                        push_data,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [$clog2(DEPTH+1)-1:0]   count_next,
  output resp_t                        head_next
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  resp_t             mem [DEPTH];
  logic [PTR_W-1:0]  rptr;
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr_next;
  logic [CNT_W-1:0]  cnt;

  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign count = cnt;
  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

  // Next head comes from the incoming push when no stored entry remains.
  always_comb begin
    count_next = cnt + CNT_W'(push) - CNT_W'(pop);
    rptr_next  = pop ? inc(rptr) : rptr;
    head_next  = mem[rptr_next];
    if ((cnt - CNT_W'(pop)) == '0) begin
      head_next = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= inc(wptr);
      if (pop)  rptr <= inc(rptr);
      cnt <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/sram_like_slave.sv
// Word-addressed RAM behind the sram-like bus with programmable accept and
// response delays; responses return strictly in acceptance order.
module sram_like_slave
  import sram_like_slave_pkg::*;
#(
  parameter int unsigned MEM_AW    = 16,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned DLY_W     = DLY_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  sram_like_slave_if.slave bus,
  input  logic [DLY_W-1:0] addr_dly,
  input  logic [DLY_W-1:0] data_dly
);

  localparam int unsigned CNT_W     = $clog2(MAX_OUTST + 1);
  localparam int unsigned MEM_WORDS = 2 ** MEM_AW;

  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic [MEM_AW-1:0] idx;
  logic [DLY_W-1:0]  a_cnt;
  logic [DLY_W-1:0]  d_cnt;
  logic [DLY_W-1:0]  d_cnt_next;
  logic              addr_ok;
  logic              fire_next;
  logic              data_q;
  logic [DATA_W-1:0] rdata_q;

  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  resp_t             push_data;
  resp_t             head_next;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;

  logic              unused_bits;
  assign unused_bits = ^{bus.size, bus.addr[ADDR_W-1:MEM_AW+2], bus.addr[1:0]};

  assign idx = bus.addr[MEM_AW+1:2];

  // Acceptance: full queue blocks even if a pop happens this same cycle.
  always_comb begin
    addr_ok = bus.req && (a_cnt >= addr_dly) && (count < CNT_W'(MAX_OUTST));
    push    = addr_ok && !full;
    pop     = data_q && !empty;
    push_data.wr    = bus.wr;
    push_data.rdata = mem[idx];
  end

  assign bus.addr_ok = addr_ok;
  assign bus.data_ok = data_q;
  assign bus.rdata   = rdata_q;

  always_ff @(posedge clk) begin
    if (reset || !bus.req || addr_ok) begin
      a_cnt <= '0;
    end else if (a_cnt != '1) begin
      a_cnt <= a_cnt + DLY_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push && bus.wr) begin
      for (int i = 0; i < int'(STRB_W); i++) begin
        if (bus.wstrb[i]) mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  sram_like_slave_resp_fifo #(.DEPTH(MAX_OUTST)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .count_next (count_next),
    .head_next  (head_next)
  );

  // Head age as seen after this edge; restarts whenever a new head appears.
  always_comb begin
    d_cnt_next = '0;
    if (!pop && !empty && (count_next != '0)) begin
      d_cnt_next = (d_cnt == '1) ? d_cnt : d_cnt + DLY_W'(1);
    end
    fire_next = (count_next != '0) && (d_cnt_next >= data_dly);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_cnt   <= '0;
      data_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      d_cnt   <= d_cnt_next;
      data_q  <= fire_next;
      rdata_q <= (fire_next && !head_next.wr) ? head_next.rdata : '0;
    end
  end

endmodule

// File: tb/tb_sram_like_slave.sv
// Cycle-by-cycle vector bench for sram_like_slave plus directed latency/alias sequences.
module tb_sram_like_slave;
  import sram_like_slave_pkg::*;

  typedef struct {
    logic        rst;
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  adly;
    logic [2:0]  ddly;
    logic        e_aok;
    logic        e_dok;
    logic [31:0] e_rd;
    logic [2:0]  e_cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] addr_dly;
  logic [2:0] data_dly;
  int         checks = 0;
  int         errors = 0;
  vec_t       vq[$];

  always #5 clk = ~clk;

  sram_like_slave_if bus ();

  sram_like_slave #(.MEM_AW(16), .MAX_OUTST(4), .DLY_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .addr_dly (addr_dly),
    .data_dly (data_dly)
  );

  function automatic vec_t mk(input logic rst, req, wr, input logic [3:0] ws,
                              input logic [31:0] a, d, input logic [2:0] ad, dd,
                              input logic aok, dok, input logic [31:0] rd,
                              input logic [2:0] cnt);
    vec_t v;
    v.rst = rst; v.req = req; v.wr = wr; v.wstrb = ws; v.addr = a; v.wdata = d;
    v.adly = ad; v.ddly = dd; v.e_aok = aok; v.e_dok = dok; v.e_rd = rd; v.e_cnt = cnt;
    return v;
  endfunction

  function automatic vec_t idle(input logic [2:0] ad, dd, input logic dok,
                                input logic [31:0] rd, input logic [2:0] cnt);
    return mk(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, ad, dd, 1'b0, dok, rd, cnt);
  endfunction

  function automatic vec_t rdv(input logic [31:0] a, input logic [2:0] ad, dd,
                               input logic aok, dok, input logic [31:0] rd,
                               input logic [2:0] cnt);
    return mk(1'b0, 1'b1, 1'b0, 4'h0, a, 32'h0, ad, dd, aok, dok, rd, cnt);
  endfunction

  function automatic vec_t wrv(input logic [31:0] a, d, input logic [3:0] ws,
                               input logic [2:0] ad, dd, input logic aok, dok,
                               input logic [31:0] rd, input logic [2:0] cnt);
    return mk(1'b0, 1'b1, 1'b1, ws, a, d, ad, dd, aok, dok, rd, cnt);
  endfunction

  task automatic drive(input logic rq, w, input logic [3:0] ws, input logic [31:0] a, d);
    bus.req   = rq;
    bus.wr    = w;
    bus.wstrb = ws;
    bus.addr  = a;
    bus.wdata = d;
    bus.size  = SIZE_WORD;
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): got 0x%0h, expected 0x%0h", name, row, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int lat;
    reset = 1'b1; addr_dly = '0; data_dly = '0;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // reset, preload mem[0], zero-delay read
    vq.push_back(mk(1, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0));
    vq.push_back(wrv(32'h1c000000, 32'h02800c0c, 4'hf, 0, 0, 1, 0, 0, 0));
    vq.push_back(idle(0, 0, 1, 32'h0, 1));
    vq.push_back(rdv(32'h1c000000, 0, 0, 1, 0, 0, 0));
    vq.push_back(idle(0, 0, 1, 32'h02800c0c, 1));
    vq.push_back(idle(0, 0, 0, 0, 0));
    // addr_dly=3: accept on 4th req cycle; drop after 2 restarts the count
    repeat (3) vq.push_back(rdv(32'h1c000000, 3, 0, 0, 0, 0, 0));
    vq.push_back(rdv(32'h1c000000, 3, 0, 1, 0, 0, 0));
    vq.push_back(idle(3, 0, 1, 32'h02800c0c, 1));
    repeat (2) vq.push_back(rdv(32'h1c000000, 3, 0, 0, 0, 0, 0));
    vq.push_back(idle(3, 0, 0, 0, 0));
    repeat (3) vq.push_back(rdv(32'h1c000000, 3, 0, 0, 0, 0, 0));
    vq.push_back(rdv(32'h1c000000, 3, 0, 1, 0, 0, 0));
    vq.push_back(idle(3, 0, 1, 32'h02800c0c, 1));
    vq.push_back(idle(0, 0, 0, 0, 0));
    // back-to-back writes of mem[1..6]
    vq.push_back(wrv(32'h04, 32'h11110001, 4'hf, 0, 0, 1, 0, 0, 0));
    vq.push_back(wrv(32'h08, 32'h11110002, 4'hf, 0, 0, 1, 1, 0, 1));
    vq.push_back(wrv(32'h0c, 32'h11110003, 4'hf, 0, 0, 1, 1, 0, 1));
    vq.push_back(wrv(32'h10, 32'h11110004, 4'hf, 0, 0, 1, 1, 0, 1));
    vq.push_back(wrv(32'h14, 32'h11110005, 4'hf, 0, 0, 1, 1, 0, 1));
    vq.push_back(wrv(32'h18, 32'h11110006, 4'hf, 0, 0, 1, 1, 0, 1));
    vq.push_back(idle(0, 0, 1, 32'h0, 1));
    vq.push_back(idle(0, 0, 0, 0, 0));
    // six reads with data_dly=3 fill the queue, then data_dly=0 drains back-to-back
    vq.push_back(rdv(32'h04, 0, 3, 1, 0, 0, 0));
    vq.push_back(rdv(32'h08, 0, 3, 1, 0, 0, 1));
    vq.push_back(rdv(32'h0c, 0, 3, 1, 0, 0, 2));
    vq.push_back(rdv(32'h10, 0, 3, 1, 0, 0, 3));
    vq.push_back(rdv(32'h14, 0, 3, 0, 1, 32'h11110001, 4));
    vq.push_back(rdv(32'h14, 0, 3, 1, 0, 0, 3));
    vq.push_back(rdv(32'h18, 0, 3, 0, 0, 0, 4));
    vq.push_back(rdv(32'h18, 0, 3, 0, 0, 0, 4));
    vq.push_back(rdv(32'h18, 0, 3, 0, 1, 32'h11110002, 4));
    vq.push_back(rdv(32'h18, 0, 3, 1, 0, 0, 3));
    vq.push_back(idle(0, 0, 0, 0, 4));
    vq.push_back(idle(0, 0, 1, 32'h11110003, 4));
    vq.push_back(idle(0, 0, 1, 32'h11110004, 3));
    vq.push_back(idle(0, 0, 1, 32'h11110005, 2));
    vq.push_back(idle(0, 0, 1, 32'h11110006, 1));
    vq.push_back(idle(0, 0, 0, 0, 0));
    // partial write merge
    vq.push_back(wrv(32'h20, 32'haaaaaaaa, 4'hf, 0, 0, 1, 0, 0, 0));
    vq.push_back(wrv(32'h20, 32'h11223344, 4'h6, 0, 0, 1, 1, 0, 1));
    vq.push_back(rdv(32'h20, 0, 0, 1, 1, 0, 1));
    vq.push_back(idle(0, 0, 1, 32'haa2233aa, 1));
    vq.push_back(idle(0, 0, 0, 0, 0));
    // read snapshot survives a later write to the same word
    vq.push_back(rdv(32'h20, 0, 2, 1, 0, 0, 0));
    vq.push_back(wrv(32'h20, 32'h55667788, 4'hf, 0, 2, 1, 0, 0, 1));
    vq.push_back(idle(0, 2, 0, 0, 2));
    vq.push_back(idle(0, 2, 1, 32'haa2233aa, 2));
    vq.push_back(idle(0, 2, 0, 0, 1));
    vq.push_back(idle(0, 2, 0, 0, 1));
    vq.push_back(idle(0, 2, 1, 32'h0, 1));
    vq.push_back(idle(0, 0, 0, 0, 0));
    vq.push_back(rdv(32'h20, 0, 0, 1, 0, 0, 0));
    vq.push_back(idle(0, 0, 1, 32'h55667788, 1));
    vq.push_back(idle(0, 0, 0, 0, 0));
    // reset with three outstanding drops them
    vq.push_back(rdv(32'h04, 0, 7, 1, 0, 0, 0));
    vq.push_back(rdv(32'h08, 0, 7, 1, 0, 0, 1));
    vq.push_back(rdv(32'h0c, 0, 7, 1, 0, 0, 2));
    vq.push_back(mk(1, 0, 0, 4'h0, 32'h0, 32'h0, 0, 7, 0, 0, 32'h0, 3));
    vq.push_back(idle(0, 0, 0, 0, 0));
    vq.push_back(idle(0, 0, 0, 0, 0));
    vq.push_back(rdv(32'h04, 0, 0, 1, 0, 0, 0));
    vq.push_back(idle(0, 0, 1, 32'h11110001, 1));
    vq.push_back(idle(0, 0, 0, 0, 0));

    foreach (vq[i]) begin
      @(negedge clk);
      reset    = vq[i].rst;
      addr_dly = vq[i].adly;
      data_dly = vq[i].ddly;
      drive(vq[i].req, vq[i].wr, vq[i].wstrb, vq[i].addr, vq[i].wdata);
      #1;
      chk("addr_ok", i, 32'(bus.addr_ok), 32'(vq[i].e_aok));
      chk("data_ok", i, 32'(bus.data_ok), 32'(vq[i].e_dok));
      chk("count", i, 32'(dut.count), 32'(vq[i].e_cnt));
      if (vq[i].e_dok || i == 0) chk("rdata", i, bus.rdata, vq[i].e_rd);
    end

    // upper address bits alias onto the low word index
    @(negedge clk); addr_dly = 3'd0; data_dly = 3'd0;
    drive(1'b1, 1'b1, 4'hf, 32'h0004_0004, 32'hdeadbeef);
    #1 chk("alias_wr_aok", -1, 32'(bus.addr_ok), 32'd1);
    @(negedge clk); drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1 chk("alias_wr_dok", -1, 32'(bus.data_ok), 32'd1);
    chk("alias_wr_rdata", -1, bus.rdata, 32'h0);
    @(negedge clk); drive(1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    #1 chk("alias_rd_aok", -1, 32'(bus.addr_ok), 32'd1);
    @(negedge clk); drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1 chk("alias_rd_dok", -1, 32'(bus.data_ok), 32'd1);
    chk("alias_rd_rdata", -1, bus.rdata, 32'hdeadbeef);

    // addr_dly=5 / data_dly=4 latencies measured with bounded waits
    @(negedge clk); addr_dly = 3'd5; data_dly = 3'd4;
    drive(1'b1, 1'b0, 4'h0, 32'h1c000000, 32'h0);
    n = 0;
    #1;
    while (!bus.addr_ok && n < 12) begin
      @(negedge clk); #1; n++;
    end
    chk("addr_wait", -1, 32'(n), 32'd5);
    @(negedge clk); drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    lat = 1;
    #1;
    while (!bus.data_ok && lat < 12) begin
      @(negedge clk); #1; lat++;
    end
    chk("data_lat", -1, 32'(lat), 32'd5);
    chk("lat_rdata", -1, bus.rdata, 32'h02800c0c);
    @(negedge clk);
    #1 chk("single_pulse", -1, 32'(bus.data_ok), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
